// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that drives an external combinational ALU.
// Uses only ADD and RSH; latency is fixed at 3W ALU cycles plus one DONE cycle.

package alu_mult_seq_pkg;
   typedef enum logic [2:0] {
      CLR = 3'd0,
      ADD = 3'd1,
      SUB = 3'd2,
      AND = 3'd3,
      OR  = 3'd4,
      XOR = 3'd5,
      LSH = 3'd6,
      RSH = 3'd7
   } op_mne;
endpackage

module alu_mult_seq
   import alu_mult_seq_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           start,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic           prod_zero,
   output op_mne          alu_op,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic           alu_sc_in,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_sc_out
);

   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {StIdle, StAdd, StShh, StShl, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    p_hi_q, p_hi_d;
   logic [W-1:0]    p_lo_q, p_lo_d;
   logic            c_q, c_d;
   logic            s_q, s_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         c_q     <= 1'b0;
         s_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         c_q     <= c_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      c_d       = c_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      alu_op    = CLR;
      alu_a     = '0;
      alu_b     = '0;
      alu_sc_in = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = mcand;
               p_hi_d  = '0;
               p_lo_d  = mplier;
               cnt_d   = '0;
               c_d     = 1'b0;
               s_d     = 1'b0;
               state_d = StAdd;
            end
         end
         StAdd: begin
            // Always issue the add (B=0 for a zero bit) so latency never depends on data.
            alu_op  = ADD;
            alu_a   = p_hi_q;
            alu_b   = p_lo_q[0] ? a_q : '0;
            p_hi_d  = alu_out;
            c_d     = alu_sc_out;
            state_d = StShh;
         end
         StShh: begin
            alu_op    = RSH;
            alu_a     = p_hi_q;
            alu_sc_in = c_q;
            p_hi_d    = alu_out;
            s_d       = alu_sc_out;
            state_d   = StShl;
         end
         StShl: begin
            alu_op    = RSH;
            alu_a     = p_lo_q;
            alu_sc_in = s_q;
            p_lo_d    = alu_out;
            if (cnt_q == CntW'(W - 1)) begin
               state_d = StDone;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = StAdd;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign product   = {p_hi_q, p_lo_q};
   assign prod_zero = ~|product;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: behavioural ALU, cycle-countdown reference model, per-cycle compare,
// and directed vectors with literal expected products.

module tb_alu_mult_seq;
   import alu_mult_seq_pkg::*;

   localparam int unsigned W   = 8;
   localparam int          Lat = 3 * W + 1;

   logic           Clk;
   logic           Reset;
   logic           start;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic           prod_zero;
   op_mne          alu_op;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic           alu_sc_in;
   logic [W-1:0]   alu_out;
   logic           alu_sc_out;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   alu_mult_seq #(.W(W)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .mcand      (mcand),
      .mplier     (mplier),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .prod_zero  (prod_zero),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sc_in  (alu_sc_in),
      .alu_out    (alu_out),
      .alu_sc_out (alu_sc_out)
   );

   // Behavioural combinational ALU.
   always_comb begin
      alu_out    = '0;
      alu_sc_out = 1'b0;
      case (alu_op)
         ADD: {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_sc_in};
         RSH: begin
            alu_out    = {alu_sc_in, alu_a[W-1:1]};
            alu_sc_out = alu_a[0];
         end
         default: begin
            alu_out    = '0;
            alu_sc_out = 1'b0;
         end
      endcase
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference: an operation is a countdown of Lat cycles; the result is simply mcand*mplier.
   int             m_rem  = 0;
   logic [2*W-1:0] m_prod = '0;

   always @(posedge Clk) begin
      if (Reset) begin
         m_rem  <= 0;
         m_prod <= '0;
      end else if (m_rem == 0) begin
         if (start) begin
            m_rem  <= Lat;
            m_prod <= (2*W)'(mcand) * (2*W)'(mplier);
         end
      end else begin
         m_rem <= m_rem - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge Clk) begin
      #1;
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_rem != 0));
         check("done", 32'(done), 32'(m_rem == 1));
         if (m_rem <= 1) begin
            check("product", 32'(product), 32'(m_prod));
            check("prod_zero", 32'(prod_zero), 32'(m_prod == '0));
         end
         check("alu_op_legal", 32'(alu_op == CLR || alu_op == ADD || alu_op == RSH), 32'd1);
      end
   end

   // Start one op; poke1/poke2 are cycle numbers at which a stray start is pulsed (0 = none).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string tag,
                         input int poke1, input int poke2);
      int lat;
      int busy_cnt;
      @(negedge Clk);
      mcand  = a;
      mplier = b;
      start  = 1'b1;
      @(posedge Clk);
      #1;
      start    = 1'b0;
      mcand    = ~a;
      mplier   = ~b;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (lat == poke1 || lat == poke2) begin
            start  = 1'b1;
            mcand  = 8'h33;
            mplier = 8'h44;
         end else begin
            start = 1'b0;
         end
         @(posedge Clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (busy) busy_cnt++;
      check({tag, "_latency"}, 32'(lat), 32'(Lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(Lat));
      check({tag, "_product"}, 32'(product), 32'(exp));
      check({tag, "_prod_zero"}, 32'(prod_zero), 32'(exp == '0));
      @(posedge Clk);
      #1;
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
      check({tag, "_held"}, 32'(product), 32'(exp));
   endtask

   initial begin
      int lat;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      Reset  = 1'b1;
      start  = 1'b0;
      mcand  = '0;
      mplier = '0;
      repeat (2) @(posedge Clk);
      #1;
      Reset  = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_prod_zero", 32'(prod_zero), 32'd1);

      run_op(8'h0F, 8'h0F, 16'h00E1, "0f_x_0f", 0, 0);
      run_op(8'hFF, 8'hFF, 16'hFE01, "ff_x_ff", 0, 0);
      run_op(8'hA5, 8'h00, 16'h0000, "a5_x_00", 0, 0);
      run_op(8'h00, 8'h80, 16'h0000, "00_x_80", 0, 0);
      run_op(8'h80, 8'h02, 16'h0100, "80_x_02_pokes", 5, 24);

      // Reset during cycle 12 of an operation.
      @(negedge Clk);
      mcand  = 8'h55;
      mplier = 8'h66;
      start  = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_product", 32'(product), 32'd0);
      check("midrst_prod_zero", 32'(prod_zero), 32'd1);
      run_op(8'h03, 8'h07, 16'h0015, "03_x_07", 0, 0);

      // start held high across DONE: a second op is accepted in the first IDLE cycle.
      @(negedge Clk);
      mcand  = 8'h10;
      mplier = 8'h10;
      start  = 1'b1;
      @(posedge Clk);
      #1;
      mcand  = 8'h02;
      mplier = 8'h03;
      lat    = 1;
      while (!done && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      check("held_latency", 32'(lat), 32'(Lat));
      check("held_product", 32'(product), 32'h0100);
      @(posedge Clk);
      #1;
      check("held_done_pulse", 32'(done), 32'd0);
      check("held_idle", 32'(busy), 32'd0);
      @(posedge Clk);
      #1;
      start = 1'b0;
      check("held_reaccept", 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      check("held2_latency", 32'(lat), 32'(Lat));
      check("held2_product", 32'(product), 32'h0006);
      @(posedge Clk);
      #1;

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), "rand", 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle unsigned multiplier controller. It is the initiator on the ALU opcode interface: each cycle it drives OP/InputA/InputB/SC_in to the combinational ALU and registers the returned Out/SC_out.
- Computes a 2W-bit product by shift-and-add, using only the ALU ADD and RSH opcodes from Definitions.
- Sits beside the ALU in the datapath. The top-level instantiates one ALU, wired port-for-port to this block's alu_* ports.

Parameters:
- W, 8, operand width; must match the ALU W. Product width is 2W, iteration count is W, and the counter is $clog2(W) bits.

Ports:
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mcand  input  W  multiplicand, latched on accepted start
- mplier  input  W  multiplier, latched on accepted start
- busy  output  1  high from the cycle after an accepted start through DONE inclusive
- done  output  1  one-cycle pulse; product valid this cycle and held afterwards
- product  output  2W  {P_hi,P_lo}; held until the next accepted start
- prod_zero  output  1  ~|product
- alu_op  output  op_mne  opcode to the ALU
- alu_a  output  W  ALU InputA
- alu_b  output  W  ALU InputB
- alu_sc_in  output  1  ALU SC_in
- alu_out  input  W  ALU Out
- alu_sc_out  input  1  ALU SC_out

Behaviour:
- Registers: A (mcand copy), P_hi, P_lo, c (carry), s (shift bit), cnt, state.
- Reset (synchronous, priority over everything, including mid-operation):
  - state=IDLE; A, P_hi, P_lo, c, s, cnt = 0.
  - busy=0, done=0, product=0, prod_zero=1.
  - Any in-flight multiply is abandoned.
- ALU drive is combinational from state and registers. The ALU result is consumed in the same cycle and registered at the edge.
- States and transitions:
  - IDLE: alu_op=CLR, alu_a=0, alu_b=0, alu_sc_in=0.
    - start=1 at edge: A<=mcand, P_hi<=0, P_lo<=mplier, cnt<=0, c<=0, s<=0 -> ADD.
    - Otherwise stay in IDLE.
  - ADD: alu_op=ADD, alu_a=P_hi, alu_b=(P_lo[0] ? A : 0), alu_sc_in=0.
    - Edge: P_hi<=alu_out, c<=alu_sc_out -> SHH.
  - SHH: alu_op=RSH, alu_a=P_hi, alu_b=0, alu_sc_in=c.
    - Edge: P_hi<=alu_out (= {c, P_hi[W-1:1]}), s<=alu_sc_out (= old P_hi[0]) -> SHL.
  - SHL: alu_op=RSH, alu_a=P_lo, alu_b=0, alu_sc_in=s.
    - Edge: P_lo<=alu_out.
    - If cnt==W-1 -> DONE, else cnt<=cnt+1 -> ADD.
  - DONE: done=1, alu drive as in IDLE; edge -> IDLE.
- Fixed latency, data-independent:
  - Start accepted at edge k; ADD entered at k+1.
  - 3W ALU cycles follow; DONE is the cycle after edge k+3W+1. For W=8, done is high 25 cycles after the accepting edge.
- The ADD step always issues, with B=0 when the multiplier bit is 0, so timing never depends on data.
- busy is registered: 0 in IDLE, 1 in ADD/SHH/SHL/DONE.
- done is high only in the DONE state.
- product = {P_hi,P_lo} at all times:
  - It changes during computation. The consumer uses it only when done=1 or while busy=0.
  - Its value is stable from DONE until the next accepted start.
- start behaviour:
  - While busy (including the DONE cycle): ignored, no queuing.
  - Held high continuously: a new multiply is accepted in the first IDLE cycle after DONE.
- Input sampling: mcand/mplier are sampled only at the accepting edge. Later changes have no effect.
- Carry: ADD of W-bit values is unsigned, carry into c. c is then shifted into P_hi[W-1], so no bit is ever lost and the product is exact for all operand pairs.

Test Plan:
- mcand=0x0F, mplier=0x0F, start 1 cycle -> done exactly 25 cycles after the accepting edge; product=0x00E1, prod_zero=0; busy high for 25 cycles.
- mcand=0xFF, mplier=0xFF (carry path every ADD) -> product=0xFE01.
- mcand=0xA5, mplier=0x00 -> product=0x0000, prod_zero=1, done still at cycle 25. Then mcand=0x00, mplier=0x80 -> 0x0000.
- mcand=0x80, mplier=0x02 -> 0x0100. Pulse start=1 at cycles 5 and 24 after acceptance with different operands -> ignored; result unchanged.
- Reset asserted during cycle 12 of an operation -> next edge: IDLE, busy=0, done=0, product=0. A following start with 0x03×0x07 -> product=0x0015.
- start held high with 0x10×0x10 -> product=0x0100; done pulses one cycle; second operation accepted the cycle after DONE.
- Random 1000 operand pairs against a reference model, with the real ALU instantiated -> product exact. alu_op takes only the values ADD, RSH, CLR.
